tc_mul_pipe: RTL and testbench
==============================

# tc_mul_pipe

Parametrised, pipelined signed × unsigned multiplier for the TrackletCalculator arithmetic datapath, replacing the fixed-width single-stage multiplier instances. It computes signed `din0` × unsigned `din1` over a configurable register pipeline. The pipeline carries a valid bit, stalls on a clock enable, applies an optional arithmetic right shift, and saturates to the output width with an overflow flag. It sits between the HLS-scheduled operand registers and the downstream adders and comparators in the TC core.

## Interface
- `DIN0_WIDTH`, 17, width of signed operand `din0` (2..27)
- `DIN1_WIDTH`, 16, width of unsigned operand `din1` (1..26)
- `DOUT_WIDTH`, 31, width of signed result `dout` (2..64)
- `SHIFT`, 0, arithmetic right shift applied to the full product (0..DIN0_WIDTH+DIN1_WIDTH-2)
- `LATENCY`, 3, register stages from input to output (1..4)

- `ap_clk` input 1: clock; everything is rising-edge.
- `ap_rst` input 1: reset. Synchronous to `ap_clk`, active-high.
- `ce` input 1: clock enable. 0 holds every pipeline register.
- `din_vld` input 1: operands valid.
- `din0` input DIN0_WIDTH: signed multiplicand.
- `din1` input DIN1_WIDTH: unsigned multiplier, zero-extended.
- `dout_vld` output 1: result valid.
- `dout` output DOUT_WIDTH: signed, shifted, saturated product.
- `ovf` output 1: the current `dout` was saturated. Qualified by `dout_vld`.

## Operation
- Full product P = signed(din0) × signed({1'b0, din1}). P is held in FW = DIN0_WIDTH + DIN1_WIDTH bits, which is exact for all operand values.
- Shift: S = P >>> SHIFT, arithmetic, floor toward −∞, unless the rounding option is compiled in (see Configuration).
- Saturation, with OW = FW − SHIFT:
  - If OW ≤ DOUT_WIDTH, `dout` is the sign-extension of S and `ovf` = 0.
  - Otherwise, if S > 2^(DOUT_WIDTH−1)−1, `dout` = 2^(DOUT_WIDTH−1)−1.
  - Otherwise, if S < −2^(DOUT_WIDTH−1), `dout` = −2^(DOUT_WIDTH−1).
  - In either saturated case `ovf` = 1.
- Pipeline stage split:
  - Stage 1 registers the operands and `din_vld`.
  - The multiply sits between stage 1 and the last stage. With LATENCY ≥ 3 the product is registered before the shift/saturate step.
  - The last stage registers `dout`, `ovf` and `dout_vld`.
  - With LATENCY = 4, one extra product register is inserted for DSP cascade timing.
  - With LATENCY = 1, the multiply, shift and saturate are all combinational ahead of the single register.
- Data registers load on every `ce`=1 edge regardless of valid. `dout`/`ovf` are don't-care while `dout_vld` = 0, but must be deterministic (no X after reset).

## Timing
- Reset (`ap_rst`=1 at an edge) clears every stage register: `dout_vld`=0, `dout`=0, `ovf`=0. Reset overrides `ce`.
- Reset mid-operation discards all in-flight results. The first valid output after reset deasserts appears LATENCY `ce`-cycles after the first accepted `din_vld`.
- Latency is exactly LATENCY rising edges with `ce`=1, from sampling `din_vld`/`din0`/`din1` to `dout_vld`/`dout` appearing.
- Throughput is one operation per `ce` cycle, with no bubbles.
- `ce`=0 freezes all stages, including `dout_vld`. Outputs hold their values, and no result is lost or duplicated.
- There is no backpressure beyond `ce`. The consumer must sample whenever `dout_vld`=1 and `ce`=1.
- Back-to-back operations with `din_vld` toggling every cycle are reproduced in order at the output, with the same valid pattern.

## Configuration
- `TC_MUL_ROUND_EN`:
  - When defined, the shift rounds half-up: S = (P + 2^(SHIFT−1)) >>> SHIFT when SHIFT > 0. The addition is done in FW+1 bits so it never wraps. Saturation then applies to the rounded value.
  - When undefined, the shift truncates toward −∞.
  - When SHIFT = 0, the macro has no effect.

## Test plan
- Defaults (17/16/31, SHIFT 0, LATENCY 3), `ce`=1: din0=100, din1=200, `din_vld` pulsed for 1 cycle → `dout`=20000, `ovf`=0, `dout_vld` high for exactly 1 cycle, 3 edges later.
- Defaults, saturation:
  - din0=−65536, din1=65535 → `dout`=−1073741824, `ovf`=1.
  - din0=65535, din1=65535 → `dout`=1073741823, `ovf`=1.
- Defaults, streaming with stall: 8 consecutive valid pairs (k, 3), k=1..8, with `ce`=0 for 2 cycles mid-stream → outputs 3, 6, …, 24 in order, none dropped or repeated. `dout_vld` and `dout` held during the stall.
- Reset mid-stream: `ap_rst`=1 for 1 cycle while 3 results are in flight → `dout_vld`=0 and `dout`=0 on the next edge, and none of the 3 results emerges afterwards.
- SHIFT=4, din0=24, din1=1:
  - without `TC_MUL_ROUND_EN` → `dout`=1.
  - with `TC_MUL_ROUND_EN` → `dout`=2.
  - din0=−25 gives −2 in both builds.
- LATENCY sweep 1..4 with random operands against a golden model → exact match, with the measured latency equal to LATENCY.

Source files
------------

// File: rtl/tc_mul_pipe.sv
// tc_mul_pipe: pipelined signed x unsigned multiplier with shift and saturation.
// Define TC_MUL_ROUND_EN to round the right shift half-up instead of truncating.
module tc_mul_pipe #(
    parameter int DIN0_WIDTH = 17,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 31,
    parameter int SHIFT      = 0,
    parameter int LATENCY    = 3
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  din_vld,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  dout_vld,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int FW  = DIN0_WIDTH + DIN1_WIDTH;
    localparam int OW  = FW - SHIFT;
    localparam int XW  = (DOUT_WIDTH > FW + 1) ? DOUT_WIDTH : FW + 1;
    localparam int NP  = (LATENCY >= 3) ? LATENCY - 2 : 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam bit SAT_EN = OW > DOUT_WIDTH;

    localparam logic [FW:0] RND =
        (SHIFT > 0) ? ({{FW{1'b0}}, 1'b1} << RSH) : '0;
    localparam logic [XW-1:0] MAXV =
        {{(XW - DOUT_WIDTH + 1){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
    localparam logic [XW-1:0] MINV =
        {{(XW - DOUT_WIDTH + 1){1'b1}}, {(DOUT_WIDTH - 1){1'b0}}};

    logic [DIN0_WIDTH-1:0] a;
    logic [DIN1_WIDTH-1:0] b;
    logic                  a_vld;

    if (LATENCY >= 2) begin : g_in
        logic [DIN0_WIDTH-1:0] a_q, a_d;
        logic [DIN1_WIDTH-1:0] b_q, b_d;
        logic                  v_q, v_d;

        always_comb begin
            a_d = a_q;
            b_d = b_q;
            v_d = v_q;
            if (ce) begin
                a_d = din0;
                b_d = din1;
                v_d = din_vld;
            end
        end

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                a_q <= '0;
                b_q <= '0;
                v_q <= 1'b0;
            end else begin
                a_q <= a_d;
                b_q <= b_d;
                v_q <= v_d;
            end
        end

        assign a     = a_q;
        assign b     = b_q;
        assign a_vld = v_q;
    end else begin : g_in_comb
        assign a     = din0;
        assign b     = din1;
        assign a_vld = din_vld;
    end

    // Both operands widened to FW bits; the FW-bit product is exact.
    logic signed [FW-1:0] a_ext;
    logic signed [FW-1:0] b_ext;
    logic signed [FW-1:0] prod;

    assign a_ext = {{DIN1_WIDTH{a[DIN0_WIDTH-1]}}, a};
    assign b_ext = {{DIN0_WIDTH{1'b0}}, b};
    assign prod  = a_ext * b_ext;

    logic [FW-1:0] p_fin;
    logic          p_vld;

    if (LATENCY >= 3) begin : g_prod
        logic [NP-1:0][FW-1:0] pr_q, pr_d;
        logic [NP-1:0]         pv_q, pv_d;

        always_comb begin
            pr_d = pr_q;
            pv_d = pv_q;
            if (ce) begin
                pr_d[0] = prod;
                pv_d[0] = a_vld;
                for (int i = 1; i < NP; i++) begin
                    pr_d[i] = pr_q[i-1];
                    pv_d[i] = pv_q[i-1];
                end
            end
        end

        always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
                pr_q <= '0;
                pv_q <= '0;
            end else begin
                pr_q <= pr_d;
                pv_q <= pv_d;
            end
        end

        assign p_fin = pr_q[NP-1];
        assign p_vld = pv_q[NP-1];
    end else begin : g_prod_comb
        assign p_fin = prod;
        assign p_vld = a_vld;
    end

    logic signed [FW:0]    pw;
    logic signed [FW:0]    sh;
    logic signed [XW-1:0]  shx;
    logic [DOUT_WIDTH-1:0] res;
    logic                  res_ovf;

    // One guard bit above the product keeps the rounding add from wrapping.
    always_comb begin
        pw = $signed({p_fin[FW-1], p_fin});
`ifdef TC_MUL_ROUND_EN
        pw = pw + $signed(RND);
`endif
        sh      = pw >>> SHIFT;
        shx     = XW'(sh);
        res     = shx[DOUT_WIDTH-1:0];
        res_ovf = 1'b0;
        if (SAT_EN && (shx > $signed(MAXV))) begin
            res     = MAXV[DOUT_WIDTH-1:0];
            res_ovf = 1'b1;
        end else if (SAT_EN && (shx < $signed(MINV))) begin
            res     = MINV[DOUT_WIDTH-1:0];
            res_ovf = 1'b1;
        end
    end

    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  vld_q, vld_d;

    always_comb begin
        dout_d = dout_q;
        ovf_d  = ovf_q;
        vld_d  = vld_q;
        if (ce) begin
            dout_d = res;
            ovf_d  = res_ovf;
            vld_d  = p_vld;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            dout_q <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
        end
    end

    assign dout     = dout_q;
    assign ovf      = ovf_q;
    assign dout_vld = vld_q;

endmodule

// File: tb/tb_tc_mul_pipe.sv
// Testbench for tc_mul_pipe: directed vectors on the default build plus
// SHIFT=4 and LATENCY 1..4 instances sharing the same stimulus.
module tb_tc_mul_pipe;
    logic        clk = 1'b0;
    logic        ap_rst;
    logic        ce;
    logic        din_vld;
    logic [16:0] din0;
    logic [15:0] din1;

    logic        dout_vld, ovf;
    logic [30:0] dout;
    logic        s4_vld, s4_ovf;
    logic [30:0] s4_dout;
    logic        l1_vld, l1_ovf, l2_vld, l2_ovf, l4_vld, l4_ovf;
    logic [30:0] l1_dout, l2_dout, l4_dout;

    always #5 clk = ~clk;

    tc_mul_pipe #(.DIN0_WIDTH(17), .DIN1_WIDTH(16), .DOUT_WIDTH(31),
                  .SHIFT(0), .LATENCY(3)) u_dut (
        .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din_vld(din_vld),
        .din0(din0), .din1(din1),
        .dout_vld(dout_vld), .dout(dout), .ovf(ovf));

    tc_mul_pipe #(.SHIFT(4), .LATENCY(3)) u_s4 (
        .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din_vld(din_vld),
        .din0(din0), .din1(din1),
        .dout_vld(s4_vld), .dout(s4_dout), .ovf(s4_ovf));

    tc_mul_pipe #(.LATENCY(1)) u_l1 (
        .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din_vld(din_vld),
        .din0(din0), .din1(din1),
        .dout_vld(l1_vld), .dout(l1_dout), .ovf(l1_ovf));

    tc_mul_pipe #(.LATENCY(2)) u_l2 (
        .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din_vld(din_vld),
        .din0(din0), .din1(din1),
        .dout_vld(l2_vld), .dout(l2_dout), .ovf(l2_ovf));

    tc_mul_pipe #(.LATENCY(4)) u_l4 (
        .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .din_vld(din_vld),
        .din0(din0), .din1(din1),
        .dout_vld(l4_vld), .dout(l4_dout), .ovf(l4_ovf));

    logic [3:0]  lv;
    logic [3:0]  lo;
    logic [30:0] ld [4];

    assign lv    = {l4_vld, dout_vld, l2_vld, l1_vld};
    assign lo    = {l4_ovf, ovf, l2_ovf, l1_ovf};
    assign ld[0] = l1_dout;
    assign ld[1] = l2_dout;
    assign ld[2] = dout;
    assign ld[3] = l4_dout;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int     d0;
        int     d1;
        longint exp;
        bit     eovf;
        bit     s4;
        longint exp_s4;
    } vec_t;

`ifdef TC_MUL_ROUND_EN
    localparam longint R24 = 2;
`else
    localparam longint R24 = 1;
`endif

    localparam longint MAXV = 1073741823;
    localparam longint MINV = -1073741824;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint s31(input logic [30:0] x);
        return longint'($signed(x));
    endfunction

    function automatic longint model(input longint a, input longint b,
                                     output bit o);
        longint p;
        p = a * b;
        o = 1'b0;
        if (p > MAXV) begin
            o = 1'b1;
            return MAXV;
        end
        if (p < MINV) begin
            o = 1'b1;
            return MINV;
        end
        return p;
    endfunction

    task automatic run_vec(input vec_t v);
        din_vld = 1'b1;
        din0    = 17'(v.d0);
        din1    = 16'(v.d1);
        step();
        din_vld = 1'b0;
        step();
        chk("vec_vld_early", dout_vld, 0);
        step();
        chk($sformatf("vec_vld(%0d*%0d)", v.d0, v.d1), dout_vld, 1);
        chk($sformatf("vec_dout(%0d*%0d)", v.d0, v.d1), s31(dout), v.exp);
        chk($sformatf("vec_ovf(%0d*%0d)", v.d0, v.d1), ovf, v.eovf);
        if (v.s4) begin
            chk($sformatf("s4_dout(%0d*%0d)", v.d0, v.d1), s31(s4_dout), v.exp_s4);
            chk("s4_ovf", s4_ovf, 0);
        end
        step();
        chk("vec_vld_one_cycle", dout_vld, 0);
    endtask

    vec_t vecs[12];

    initial begin : main
        vecs[0]  = '{100, 200, 20000, 1'b0, 1'b1, 1250};
        vecs[1]  = '{-65536, 65535, MINV, 1'b1, 1'b1, -268431360};
        vecs[2]  = '{65535, 65535, MAXV, 1'b1, 1'b1, 268427264};
        vecs[3]  = '{24, 1, 24, 1'b0, 1'b1, R24};
        vecs[4]  = '{-25, 1, -25, 1'b0, 1'b1, -2};
        vecs[5]  = '{-1, 1, -1, 1'b0, 1'b0, 0};
        vecs[6]  = '{0, 65535, 0, 1'b0, 1'b1, 0};
        vecs[7]  = '{-32768, 32768, MINV, 1'b0, 1'b1, -67108864};
        vecs[8]  = '{16384, 65535, 1073725440, 1'b0, 1'b1, 67107840};
        vecs[9]  = '{16385, 65535, MAXV, 1'b1, 1'b0, 0};
        vecs[10] = '{-16385, 65535, MINV, 1'b1, 1'b0, 0};
        vecs[11] = '{32767, 32768, 1073709056, 1'b0, 1'b1, 67106816};

        ap_rst  = 1'b1;
        ce      = 1'b1;
        din_vld = 1'b0;
        din0    = '0;
        din1    = '0;
        step();
        step();
        chk("reset_vld", dout_vld, 0);
        chk("reset_dout", s31(dout), 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_l1_dout", s31(l1_dout), 0);
        ap_rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        begin : stream
            int     idx;
            longint got[$];
            bit     pv;
            longint pd;
            idx = 0;
            pv  = dout_vld;
            pd  = s31(dout);
            for (int c = 0; c < 20; c++) begin
                ce      = (c == 4 || c == 5) ? 1'b0 : 1'b1;
                din_vld = (idx < 8);
                din0    = 17'(idx + 1);
                din1    = 16'd3;
                step();
                if (ce) begin
                    if (idx < 8) idx++;
                    if (dout_vld) got.push_back(s31(dout));
                end else begin
                    chk("stall_vld_hold", dout_vld, pv);
                    chk("stall_dout_hold", s31(dout), pd);
                end
                pv = dout_vld;
                pd = s31(dout);
            end
            ce      = 1'b1;
            din_vld = 1'b0;
            chk("stream_count", got.size(), 8);
            for (int i = 0; i < 8; i++)
                chk($sformatf("stream_data[%0d]", i),
                    (i < got.size()) ? got[i] : -1, 3 * (i + 1));
        end

        begin : rst_mid
            int seen;
            din_vld = 1'b1;
            din1    = 16'd11;
            din0    = 17'd7;
            step();
            din0 = 17'd8;
            step();
            din0 = 17'd9;
            step();
            chk("rst_pre_vld", dout_vld, 1);
            chk("rst_pre_dout", s31(dout), 77);
            ap_rst  = 1'b1;
            ce      = 1'b0;
            din_vld = 1'b0;
            step();
            chk("rst_mid_vld", dout_vld, 0);
            chk("rst_mid_dout", s31(dout), 0);
            chk("rst_mid_ovf", ovf, 0);
            ap_rst = 1'b0;
            ce     = 1'b1;
            seen   = 0;
            for (int c = 0; c < 8; c++) begin
                step();
                if (dout_vld) seen++;
            end
            chk("rst_flush_no_output", seen, 0);
        end

        begin : lat_meas
            int     lat[4];
            longint val[4];
            for (int k = 0; k < 4; k++) begin
                lat[k] = -1;
                val[k] = 0;
            end
            din_vld = 1'b1;
            din0    = 17'd5;
            din1    = 16'd6;
            for (int c = 1; c <= 8; c++) begin
                step();
                din_vld = 1'b0;
                for (int k = 0; k < 4; k++)
                    if (lv[k] && lat[k] < 0) begin
                        lat[k] = c;
                        val[k] = s31(ld[k]);
                    end
            end
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("latency_L%0d", k + 1), lat[k], k + 1);
                chk($sformatf("latency_L%0d_dout", k + 1), val[k], 30);
            end
        end

        begin : sweep
            int     hv[64];
            int     h0[64];
            int     h1[64];
            int     s;
            bit     ev;
            bit     eo;
            longint ex;
            for (int e = 1; e <= 40; e++) begin
                hv[e] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                h0[e] = int'($urandom_range(0, 131071)) - 65536;
                h1[e] = int'($urandom_range(0, 65535));
                din_vld = hv[e][0];
                din0    = 17'(h0[e]);
                din1    = 16'(h1[e]);
                step();
                for (int k = 0; k < 4; k++) begin
                    s  = e - k;
                    ev = (s >= 1) ? hv[s][0] : 1'b0;
                    chk($sformatf("sweep_L%0d_vld e%0d", k + 1, e), lv[k], ev);
                    if (ev) begin
                        ex = model(h0[s], h1[s], eo);
                        chk($sformatf("sweep_L%0d_dout e%0d", k + 1, e),
                            s31(ld[k]), ex);
                        chk($sformatf("sweep_L%0d_ovf e%0d", k + 1, e), lo[k], eo);
                    end
                end
            end
            din_vld = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
